exe_mul_unit: RTL

EXE_MUL_UNIT -- requirements
Module: exe_mul_unit

---
 rtl/exe_pkg.sv | 28 ++
 rtl/exe_mul_unit_if.sv | 29 ++
 rtl/exe_alu_core.sv | 47 ++++
 rtl/exe_mul_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared constants for the execute/multiply unit: opcodes, FSM states, status bit positions.
package exe_pkg;

    // Operation codes presented on exe_cmd
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    // Status register layout {N,Z,C,V}
    localparam int SF_N = 3;
    localparam int SF_Z = 2;
    localparam int SF_C = 1;
    localparam int SF_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/exe_mul_unit_if.sv
// Request/response bundle between the issue stage and the execute/multiply unit.
interface exe_mul_unit_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 24
);
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [3:0]        exe_cmd;
    logic              s;
    logic [DATA_W-1:0] val_1;
    logic [DATA_W-1:0] val_2;
    logic [DATA_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic              out_valid;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] branch_addr;
    logic [3:0]        status;

    modport master (
        output in_valid, flush, exe_cmd, s, val_1, val_2, pc, imm,
        input  in_ready, out_valid, alu_res, branch_addr, status
    );

    modport slave (
        input  in_valid, flush, exe_cmd, s, val_1, val_2, pc, imm,
        output in_ready, out_valid, alu_res, branch_addr, status
    );
endinterface

// File: rtl/exe_alu_core.sv
// Single-cycle combinational ALU: move, add/sub with carry, logic ops. MUL is handled by the top.
module exe_alu_core
    import exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
    output logic [DATA_W-1:0] res,
    output logic              c_out,
    output logic              v_out
);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;

    // Result and C/V per opcode; subtraction is a + ~b + carry so C reads as "no borrow"
    always_comb begin
        sum   = '0;
        res   = '0;
        c_out = 1'b0;
        v_out = 1'b0;
        case (cmd)
            OP_MOV: res = b;
            OP_MVN: res = ~b;
            OP_ADD, OP_ADC: begin
                sum   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, (cmd == OP_ADC) & c_in};
                res   = sum[MSB:0];
                c_out = sum[DATA_W];
                v_out = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, (cmd == OP_SUB) | c_in};
                res   = sum[MSB:0];
                c_out = sum[DATA_W];
                v_out = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_AND: res = a & b;
            OP_ORR: res = a | b;
            OP_EOR: res = a ^ b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/exe_mul_unit.sv
// Execute unit: single-cycle ALU ops plus an iterative shift-add multiplier retiring MUL_STEP bits/cycle.
module exe_mul_unit
    import exe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 1,
    parameter int IMM_W    = 24
) (
    input  logic           clk,
    input  logic           rst,
    exe_mul_unit_if.slave  bus
);
    localparam int MSB   = DATA_W - 1;
    localparam int STEPS = DATA_W / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS + 1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc, acc_nxt, mcand, mplier;
    logic [DATA_W-1:0] br_lat, br_sum;
    logic signed [DATA_W-1:0] imm_ext;
    logic              s_lat;
    logic              in_ready, out_valid;
    logic [DATA_W-1:0] alu_res, branch_addr;
    logic [3:0]        status;
    logic              accept, is_mul;
    logic [DATA_W-1:0] alu_out;
    logic              alu_c, alu_v;
    logic [3:0]        flags_nxt;

    exe_alu_core #(.DATA_W(DATA_W)) u_alu (
        .cmd   (bus.exe_cmd),
        .a     (bus.val_1),
        .b     (bus.val_2),
        .c_in  (status[SF_C]),
        .res   (alu_out),
        .c_out (alu_c),
        .v_out (alu_v)
    );

    assign accept    = bus.in_valid && in_ready && !bus.flush;
    assign is_mul    = (bus.exe_cmd == OP_MUL);
    assign imm_ext   = DATA_W'($signed(bus.imm[IMM_W-1:0]));
    assign br_sum    = bus.pc + DATA_W'(imm_ext <<< 2);
    assign flags_nxt = {alu_out[MSB], alu_out == '0, alu_c, alu_v};

    // One multiplier step: add MUL_STEP shifted partial products to the running sum
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) acc_nxt = acc_nxt + (mcand << i);
        end
    end

    // Control FSM with registered outputs; flush overrides everything except reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            alu_res     <= '0;
            branch_addr <= '0;
            status      <= '0;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            br_lat      <= '0;
            s_lat       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (bus.flush) begin
                state    <= ST_IDLE;
                in_ready <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            if (is_mul) begin
                                mcand    <= bus.val_1;
                                mplier   <= bus.val_2;
                                acc      <= '0;
                                cnt      <= CNT_W'(STEPS);
                                br_lat   <= br_sum;
                                s_lat    <= bus.s;
                                state    <= ST_MUL;
                                in_ready <= 1'b0;
                            end else begin
                                out_valid   <= 1'b1;
                                alu_res     <= alu_out;
                                branch_addr <= br_sum;
                                if (bus.s) status <= flags_nxt;
                            end
                        end
                    end
                    ST_MUL: begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << MUL_STEP;
                        mplier <= mplier >> MUL_STEP;
                        cnt    <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) state <= ST_DONE;
                    end
                    ST_DONE: begin
                        // MUL touches only N and Z; C and V carry over
                        out_valid   <= 1'b1;
                        alu_res     <= acc;
                        branch_addr <= br_lat;
                        if (s_lat) begin
                            status[SF_N] <= acc[MSB];
                            status[SF_Z] <= (acc == '0);
                        end
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.alu_res     = alu_res;
    assign bus.branch_addr = branch_addr;
    assign bus.status      = status;

endmodule
